// File: rtl/chip_checker_pkg.sv
// Shared constants for the chip checker vector sequencer: register map,
// bit positions within CTRL/STATUS/CFG, and FSM state codes.
package chip_checker_pkg;

    localparam int PIN_W_DEF = 14;

    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_STATUS    = 3'd1;
    localparam logic [2:0] ADDR_VEC_DATA  = 3'd2;
    localparam logic [2:0] ADDR_CFG       = 3'd3;
    localparam logic [2:0] ADDR_FAIL_OBS  = 3'd4;
    localparam logic [2:0] ADDR_ERR_COUNT = 3'd5;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_CLEAR = 2;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_FAIL     = 2;
    localparam int STAT_OVERFLOW = 3;
    localparam int STAT_ABORTED  = 4;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_FIRST_LSB = 16;

    localparam int CFG_SETTLE_LSB = 0;
    localparam int CFG_MASK_LSB   = 8;
    localparam int CFG_IRQ_EN     = 31;

    localparam int VEC_DRIVE_LSB  = 0;
    localparam int VEC_EXPECT_LSB = 16;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_SETTLE = 2'd1;
    localparam state_t S_SAMPLE = 2'd2;
    localparam state_t S_DONE   = 2'd3;

endpackage

// File: rtl/chip_checker_pin_sync.sv
// Multi-flop synchronizer that brings the asynchronous pin sense bus into clk.
module chip_checker_pin_sync #(
    parameter int W      = 14,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/chip_checker_vector_sequencer.sv
// Test-vector sequencer: applies buffered drive vectors to the pins, waits a
// settle time, compares synchronized sense pins under a mask, and reports.
module chip_checker_vector_sequencer
    import chip_checker_pkg::*;
#(
    parameter int PIN_W       = PIN_W_DEF,
    parameter int DEPTH       = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [PIN_W-1:0] out_port,
    input  logic [PIN_W-1:0] in_port,
    output logic             irq
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DEPTH8 = 8'(DEPTH);

    state_t           state;
    logic [7:0]       cnt, idx, vec_count, first_fail_idx, settle;
    logic             done, fail, overflow, aborted, irq_en;
    logic [PIN_W-1:0] mask, fail_obs, pins_sync;
    logic [15:0]      err_count;

    logic [PIN_W-1:0] drv_mem [DEPTH];
    logic [PIN_W-1:0] exp_mem [DEPTH];

    logic wr, ctrl_wr, vec_wr, cfg_wr, busy, mismatch, last;
    logic [AW-1:0] cur_ptr, nxt_ptr;
    logic unused_wdata;

    assign wr      = chipselect & ~write_n;
    assign ctrl_wr = wr && (address == ADDR_CTRL);
    assign vec_wr  = wr && (address == ADDR_VEC_DATA);
    assign cfg_wr  = wr && (address == ADDR_CFG);
    assign busy    = (state == S_SETTLE) || (state == S_SAMPLE);
    assign cur_ptr = idx[AW-1:0];
    assign nxt_ptr = AW'(idx + 8'd1);
    assign last    = (idx == vec_count - 8'd1);
    assign mismatch = ((pins_sync ^ exp_mem[cur_ptr]) & mask) != '0;
    assign irq     = done & irq_en;
    assign unused_wdata = writedata[30];

    chip_checker_pin_sync #(.W(PIN_W), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (pins_sync)
    );

    // NOTE: the vector RAM has no reset; only vec_count decides which entries are valid.
    always_ff @(posedge clk) begin
        if (vec_wr && !busy && vec_count != DEPTH8) begin
            drv_mem[vec_count[AW-1:0]] <= writedata[VEC_DRIVE_LSB  +: PIN_W];
            exp_mem[vec_count[AW-1:0]] <= writedata[VEC_EXPECT_LSB +: PIN_W];
        end
    end

    // NOTE: all state updates use <= so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;   cnt <= '0;       idx <= '0;
            vec_count <= '0;   first_fail_idx <= '0;
            settle <= 8'd4;    mask <= '1;      irq_en <= 1'b0;
            done <= 1'b0;      fail <= 1'b0;    overflow <= 1'b0;  aborted <= 1'b0;
            fail_obs <= '0;    err_count <= '0; out_port <= '0;
        end else begin
            if (cfg_wr) begin
                settle <= writedata[CFG_SETTLE_LSB +: 8];
                mask   <= writedata[CFG_MASK_LSB +: PIN_W];
                irq_en <= writedata[CFG_IRQ_EN];
            end
            if (vec_wr && !busy) begin
                if (vec_count == DEPTH8) overflow  <= 1'b1;
                else                     vec_count <= vec_count + 8'd1;
            end

            if (busy && ctrl_wr && writedata[CTRL_ABORT]) begin
                state    <= S_IDLE;
                out_port <= '0;
                aborted  <= 1'b1;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (ctrl_wr && writedata[CTRL_CLEAR]) begin
                            vec_count <= '0;
                            overflow  <= 1'b0;
                            done      <= 1'b0;
                            state     <= S_IDLE;
                        end else if (ctrl_wr && writedata[CTRL_START] && !writedata[CTRL_ABORT]) begin
                            if (vec_count != '0) begin
                                out_port       <= drv_mem[0];
                                idx            <= '0;
                                cnt            <= settle;
                                done           <= 1'b0;
                                fail           <= 1'b0;
                                aborted        <= 1'b0;
                                err_count      <= '0;
                                first_fail_idx <= '0;
                                fail_obs       <= '0;
                                state          <= S_SETTLE;
                            end else begin
                                done  <= 1'b1;
                                fail  <= 1'b0;
                                state <= S_DONE;
                            end
                        end
                    end
                    S_SETTLE: begin
                        if (cnt == '0) state <= S_SAMPLE;
                        else           cnt   <= cnt - 8'd1;
                    end
                    S_SAMPLE: begin
                        if (mismatch) begin
                            if (!fail) begin
                                fail           <= 1'b1;
                                first_fail_idx <= idx;
                                fail_obs       <= pins_sync;
                            end
                            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        end
                        if (last) begin
                            out_port <= '0;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            idx      <= idx + 8'd1;
                            out_port <= drv_mem[nxt_ptr];
                            cnt      <= settle;
                            state    <= S_SETTLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // NOTE: default first so no path through the case leaves readdata unassigned.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_STATUS: begin
                readdata[STAT_BUSY]     = busy;
                readdata[STAT_DONE]     = done;
                readdata[STAT_FAIL]     = fail;
                readdata[STAT_OVERFLOW] = overflow;
                readdata[STAT_ABORTED]  = aborted;
                readdata[STAT_COUNT_LSB +: 8] = vec_count;
                readdata[STAT_FIRST_LSB +: 8] = first_fail_idx;
            end
            ADDR_CFG: begin
                readdata[CFG_SETTLE_LSB +: 8]   = settle;
                readdata[CFG_MASK_LSB +: PIN_W] = mask;
                readdata[CFG_IRQ_EN]            = irq_en;
            end
            ADDR_FAIL_OBS:  readdata[PIN_W-1:0] = fail_obs;
            ADDR_ERR_COUNT: readdata[15:0]      = err_count;
            default:        readdata = '0;
        endcase
    end

endmodule

// File: doc/chip_checker_vector_sequencer.md
Name: chip_checker_vector_sequencer

Overview:
Hardware test-vector sequencer for the chip checker. It owns the 14-bit pin-drive output port and replaces direct CPU pin writes during a test run. Software loads drive/expect vector pairs and settings over an Avalon-MM slave, then starts a run. The block applies each vector to the device under test, waits a programmable settle time, samples the synchronized pin inputs, compares them under a mask, and reports pass/fail, the first failing index and an error count.

Parameters:
PIN_W, 14, width of pin drive/sense ports and vector fields
DEPTH, 64, vector buffer entries (2..255)
SYNC_STAGES, 2, flops in the in_port synchronizer

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
address  in  3  Avalon register index
chipselect  in  1  Avalon select
write_n  in  1  Avalon write strobe, active low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, combinational from address, zero wait states
out_port  out  PIN_W  registered pin drive to the device under test
in_port  in  PIN_W  asynchronous pin sense from the device under test
irq  out  1  level interrupt = done & irq_en

Behaviour:
- Register write occurs when chipselect & ~write_n. Unused bits read 0. Undefined addresses read 0, and writes to them are ignored.
- Address 0, CTRL (W, self-clearing): bit0 start, bit1 abort, bit2 clear buffer.
- Address 1, STATUS (R): bit0 busy, bit1 done, bit2 fail, bit3 overflow, bit4 aborted, [15:8] vec_count, [23:16] first_fail_idx.
- Address 2, VEC_DATA (W): [13:0] drive, [29:16] expect. Writes buffer[vec_count] and increments vec_count. The write is dropped when busy. When vec_count==DEPTH, the write is dropped and overflow is set.
- Address 3, CFG (RW): [7:0] settle, [21:8] mask, [31] irq_en.
- Address 4, FAIL_OBS (R): synchronized pins captured at the first failure.
- Address 5, ERR_COUNT (R): [15:0] count of failing vectors, saturating at 0xFFFF.
- Reset values: out_port=0, irq=0, all STATUS fields 0, vec_count=0, settle=4, mask=all ones, irq_en=0, FAIL_OBS=0, ERR_COUNT=0.
- in_port passes through SYNC_STAGES flops (sub-module) before comparison. Software keeps settle >= SYNC_STAGES. The block does not enforce this.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
  - IDLE + start with vec_count>0: at the next edge, out_port<=buffer[0].drive, idx<=0, cnt<=settle, busy<=1, done/fail/aborted/ERR_COUNT/first_fail_idx/FAIL_OBS cleared, state SETTLE.
  - IDLE + start with vec_count==0: done<=1, fail<=0, state DONE. out_port is unchanged.
  - SETTLE: cnt decrements each cycle. When cnt==0, go to SAMPLE. SETTLE lasts settle+1 cycles.
  - SAMPLE (1 cycle): mismatch = ((pins_sync ^ expect) & mask) != 0. On the first mismatch of a run: fail<=1, first_fail_idx<=idx, FAIL_OBS<=pins_sync. Each mismatch increments ERR_COUNT.
  - SAMPLE exit when idx==vec_count-1: out_port<=0, busy<=0, done<=1, state DONE.
  - SAMPLE exit otherwise: idx++, out_port<=next drive, cnt<=settle, state SETTLE.
  - Each vector therefore takes settle+2 cycles.
  - DONE: accepts start exactly as IDLE does. Clear buffer returns to IDLE.
- Start while busy is ignored. Clear buffer while busy is ignored.
- Clear buffer when not busy: vec_count<=0, overflow<=0, done<=0.
- Abort while busy: at the next edge, state IDLE, out_port<=0, busy<=0, aborted<=1, done stays 0. fail and ERR_COUNT keep partial results.
- Abort and start in the same write: abort wins, and start is ignored even from IDLE.
- CFG writes during a run take effect at the next settle load.
- Reset mid-run forces all reset values within one cycle.

Decomposition:
- Shared package chip_checker_pkg holds:
  - register address constants (0..5)
  - STATUS/CTRL/CFG bit positions
  - state enum
  - PIN_W default
- Sub-module chip_checker_pin_sync: parameterized SYNC_STAGES-deep synchronizer with synchronous reset.
- The vector buffer is an inferred RAM inside the top, with synchronous write and asynchronous read or one-entry prefetch. With prefetch, the required timing above still holds.

Test Plan:
- Load 3 vectors (drive 0x0001/0x0002/0x0004, expect equal), loop in_port=out_port, settle=4, start -> out_port steps 0x0001,0x0002,0x0004 at 6-cycle spacing, then returns to 0. done=1, fail=0, ERR_COUNT=0, irq=1 when irq_en=1.
- Same run, but force in_port bit 3 high during vector 1 -> fail=1, first_fail_idx=1, FAIL_OBS=0x000A, ERR_COUNT=1. Repeat with mask bit3=0 -> fail=0.
- Write 65 vectors with DEPTH=64 -> vec_count=64, overflow=1. Clear buffer -> vec_count=0, overflow=0. Start with an empty buffer -> done=1 on the next cycle, out_port unchanged.
- Abort during vector 2 of 4 -> next cycle busy=0, aborted=1, done=0, out_port=0. A start write during the run was ignored. Start+abort in one write from IDLE -> stays IDLE.
- Assert reset mid-SETTLE -> next cycle out_port=0, STATUS=0, CFG settle=4, mask=0x3FFF, irq=0. VEC_DATA write while busy -> vec_count unchanged.
